tdm_demux: RTL and testbench

- Time-division demultiplexer: the inverse of the team's selection-based 2:1 MUX.
- Accepts one shared data stream carrying CHANNELS interleaved words per frame, marked by a frame-sync flag on slot 0.
- Collects each complete frame into a shadow bank, then publishes all channels in parallel with a one-cycle valid pulse.
- Sits between a serial/TDM source and per-channel consumers.

---
 rtl/tdm_demux_if.sv | 27 ++
 rtl/tdm_demux.sv | 97 +++++++++
 tb/tb_tdm_demux.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - TDM stream input and parallel channel output bundle for tdm_demux
interface tdm_demux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SW = $clog2(CHANNELS);

    logic [WIDTH-1:0]          din;
    logic                      din_valid;
    logic                      fsync;
    logic                      clr_err;
    logic [CHANNELS*WIDTH-1:0] dout;
    logic                      dout_valid;
    logic                      locked;
    logic [SW-1:0]             slot;
    logic                      sync_err;

    modport master (
        output din, din_valid, fsync, clr_err,
        input  dout, dout_valid, locked, slot, sync_err
    );

    modport slave (
        input  din, din_valid, fsync, clr_err,
        output dout, dout_valid, locked, slot, sync_err
    );
endinterface

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM demultiplexer: frame-synced slot collection, parallel publish per frame
module tdm_demux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux_if.slave   bus
);
    localparam int            SW   = $clog2(CHANNELS);
    localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);
    localparam logic [SW-1:0] ONE  = SW'(1);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t                    state_q, state_d;
    logic [SW-1:0]             slot_q, slot_d;
    logic                      err_q, err_d;
    logic                      wr_en;
    logic [SW-1:0]             wr_idx;
    logic                      publish;
    logic [CHANNELS*WIDTH-1:0] dout_q, dout_d;
    logic                      dout_valid_q;
    logic [WIDTH-1:0]          shadow_q [CHANNELS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            err_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            for (int k = 0; k < CHANNELS - 1; k++) shadow_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            err_q        <= err_d;
            dout_valid_q <= publish;
            if (publish) dout_q <= dout_d;
            for (int k = 0; k < CHANNELS - 1; k++)
                if (wr_en && wr_idx == k[SW-1:0]) shadow_q[k] <= bus.din;
        end
    end

    // The last slot is never stored: it goes straight into dout alongside the shadow bank.
    always_comb begin
        dout_d = '0;
        for (int k = 0; k < CHANNELS - 1; k++) dout_d[k*WIDTH +: WIDTH] = shadow_q[k];
        dout_d[(CHANNELS-1)*WIDTH +: WIDTH] = bus.din;
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        err_d   = err_q & ~bus.clr_err;
        wr_en   = 1'b0;
        wr_idx  = '0;
        publish = 1'b0;
        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.fsync) begin
                        wr_en   = 1'b1;
                        slot_d  = ONE;
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    if (bus.fsync) begin
                        // Early sync restarts the frame; the partial one is dropped unpublished.
                        if (slot_q != '0) err_d = 1'b1;
                        wr_en  = 1'b1;
                        slot_d = ONE;
                    end else if (slot_q == '0) begin
                        err_d   = 1'b1;
                        slot_d  = '0;
                        state_d = HUNT;
                    end else if (slot_q == LAST) begin
                        publish = 1'b1;
                        slot_d  = '0;
                    end else begin
                        wr_en  = 1'b1;
                        wr_idx = slot_q;
                        slot_d = slot_q + ONE;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.locked     = (state_q == LOCK);
    assign bus.slot       = slot_q;
    assign bus.sync_err   = err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - directed self-checking bench for tdm_demux
module tb_tdm_demux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   pulses = 0;

    tdm_demux_if #(.WIDTH(8), .CHANNELS(4)) bus ();

    tdm_demux #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.dout_valid === 1'b1) pulses++;

    task automatic send(input logic [7:0] d, input logic f);
        @(negedge clk);
        bus.din       = d;
        bus.fsync     = f;
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic f);
        @(negedge clk);
        bus.din_valid = 1'b0;
        bus.fsync     = f;
        bus.clr_err   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.din_valid = 1'b0;
        bus.fsync     = 1'b0;
        bus.clr_err   = 1'b0;
        bus.din       = 8'h00;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (bus.dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected %h", bus.dout, 32'h0); end
        n_checks++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b expected 0", bus.dout_valid); end
        n_checks++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", bus.locked); end
        n_checks++; if (bus.slot !== 2'd0) begin n_fail++; $display("FAIL reset_slot: got %0d expected 0", bus.slot); end
        n_checks++; if (bus.sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err: got %b expected 0", bus.sync_err); end
    endtask

    task automatic test_basic_frame();
        int p0;
        p0 = pulses;
        send(8'h11, 1'b1);
        n_checks++; if (bus.locked !== 1'b1 || bus.slot !== 2'd1) begin n_fail++; $display("FAIL basic_lock: got locked=%b slot=%0d expected 1/1", bus.locked, bus.slot); end
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        n_checks++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_pulse: got %b expected 0", bus.dout_valid); end
        send(8'h44, 1'b0);
        n_checks++; if (bus.dout !== 32'h44332211) begin n_fail++; $display("FAIL basic_dout: got %h expected %h", bus.dout, 32'h44332211); end
        n_checks++; if (bus.dout_valid !== 1'b1) begin n_fail++; $display("FAIL basic_dout_valid: got %b expected 1", bus.dout_valid); end
        n_checks++; if (bus.slot !== 2'd0 || bus.locked !== 1'b1 || bus.sync_err !== 1'b0) begin n_fail++; $display("FAIL basic_status: got slot=%0d locked=%b err=%b expected 0/1/0", bus.slot, bus.locked, bus.sync_err); end
        idle(1, 1'b0);
        n_checks++; if (bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b expected 0", bus.dout_valid); end
        n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL basic_pulse_count: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_hunt_ignore();
        int p0;
        do_reset();
        p0 = pulses;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        n_checks++; if (bus.locked !== 1'b0 || bus.slot !== 2'd0) begin n_fail++; $display("FAIL hunt_stay: got locked=%b slot=%0d expected 0/0", bus.locked, bus.slot); end
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        n_checks++; if (bus.dout !== 32'h04030201) begin n_fail++; $display("FAIL hunt_dout: got %h expected %h", bus.dout, 32'h04030201); end
        idle(1, 1'b0);
        n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL hunt_pulse_count: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_gaps();
        int p0;
        logic [7:0] words [4];
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            send(words[i], (i == 0));
            if (i < 3) begin
                idle(3, 1'b1);
                n_checks++; if (bus.slot !== 2'(i + 1)) begin n_fail++; $display("FAIL gap_slot_hold: got %0d expected %0d", bus.slot, i + 1); end
            end
        end
        n_checks++; if (bus.dout !== 32'h44332211) begin n_fail++; $display("FAIL gap_dout: got %h expected %h", bus.dout, 32'h44332211); end
        idle(1, 1'b0);
        n_checks++; if (pulses - p0 !== 1 || bus.sync_err !== 1'b0) begin n_fail++; $display("FAIL gap_pulse_err: got pulses=%0d err=%b expected 1/0", pulses - p0, bus.sync_err); end
    endtask

    task automatic test_early_sync();
        int p0;
        p0 = pulses;
        send(8'h01, 1'b1);
        send(8'h02, 1'b0);
        send(8'h10, 1'b1);
        n_checks++; if (bus.sync_err !== 1'b1 || bus.slot !== 2'd1 || bus.locked !== 1'b1) begin n_fail++; $display("FAIL early_err: got err=%b slot=%0d locked=%b expected 1/1/1", bus.sync_err, bus.slot, bus.locked); end
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        n_checks++; if (pulses - p0 !== 0) begin n_fail++; $display("FAIL early_no_partial: got %0d expected 0", pulses - p0); end
        send(8'h40, 1'b0);
        n_checks++; if (bus.dout !== 32'h40302010) begin n_fail++; $display("FAIL early_dout: got %h expected %h", bus.dout, 32'h40302010); end
        idle(1, 1'b0);
        n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL early_pulse_count: got %0d expected 1", pulses - p0); end
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (bus.sync_err !== 1'b0) begin n_fail++; $display("FAIL early_clr: got %b expected 0", bus.sync_err); end
        idle(1, 1'b0);
    endtask

    task automatic test_missing_sync();
        int p0;
        p0 = pulses;
        @(negedge clk);
        bus.clr_err = 1'b1;
        send(8'h55, 1'b0);
        bus.clr_err = 1'b0;
        n_checks++; if (bus.sync_err !== 1'b1) begin n_fail++; $display("FAIL missing_set_wins: got %b expected 1", bus.sync_err); end
        n_checks++; if (bus.locked !== 1'b0 || bus.slot !== 2'd0) begin n_fail++; $display("FAIL missing_unlock: got locked=%b slot=%0d expected 0/0", bus.locked, bus.slot); end
        send(8'h56, 1'b0);
        send(8'h57, 1'b0);
        send(8'h58, 1'b0);
        n_checks++; if (bus.locked !== 1'b0 || pulses - p0 !== 0 || bus.dout !== 32'h40302010) begin n_fail++; $display("FAIL missing_ignore: got locked=%b pulses=%0d dout=%h expected 0/0/40302010", bus.locked, pulses - p0, bus.dout); end
        send(8'h61, 1'b1);
        send(8'h62, 1'b0);
        send(8'h63, 1'b0);
        send(8'h64, 1'b0);
        n_checks++; if (bus.dout !== 32'h64636261 || bus.locked !== 1'b1) begin n_fail++; $display("FAIL missing_relock: got dout=%h locked=%b expected 64636261/1", bus.dout, bus.locked); end
        idle(1, 1'b0);
        n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL missing_pulse_count: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_async_reset();
        int p0;
        send(8'h71, 1'b1);
        send(8'h72, 1'b0);
        send(8'h73, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.dout !== 32'h0 || bus.dout_valid !== 1'b0) begin n_fail++; $display("FAIL async_dout: got dout=%h valid=%b expected 0/0", bus.dout, bus.dout_valid); end
        n_checks++; if (bus.locked !== 1'b0 || bus.slot !== 2'd0) begin n_fail++; $display("FAIL async_status: got locked=%b slot=%0d expected 0/0", bus.locked, bus.slot); end
        @(negedge clk);
        bus.din_valid = 1'b0;
        rst_n = 1'b1;
        p0 = pulses;
        send(8'h74, 1'b0);
        send(8'h75, 1'b0);
        send(8'h76, 1'b0);
        idle(1, 1'b0);
        n_checks++; if (pulses - p0 !== 0 || bus.locked !== 1'b0) begin n_fail++; $display("FAIL async_no_pulse: got pulses=%0d locked=%b expected 0/0", pulses - p0, bus.locked); end
        send(8'h81, 1'b1);
        send(8'h82, 1'b0);
        send(8'h83, 1'b0);
        send(8'h84, 1'b0);
        n_checks++; if (bus.dout !== 32'h84838281) begin n_fail++; $display("FAIL async_recover_dout: got %h expected %h", bus.dout, 32'h84838281); end
        idle(1, 1'b0);
        n_checks++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL async_pulse_count: got %0d expected 1", pulses - p0); end
    endtask

    initial begin
        bus.din       = 8'h00;
        bus.din_valid = 1'b0;
        bus.fsync     = 1'b0;
        bus.clr_err   = 1'b0;
        test_reset();
        test_basic_frame();
        test_hunt_ignore();
        test_gaps();
        test_early_sync();
        test_missing_sync();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
